// File: rtl/alu_sequencer.sv
// Shares one ALU between two requesters: round-robin grant, one-cycle execute,
// and a valid/ready response carrying the captured result, carry and zero flag.
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  output logic [OP_W-1:0]  alu_select,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_bus,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_id;
  logic   accept;

  // On a tie the requester that did not win last time gets the ALU
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_in_1   <= '0;
      alu_in_2   <= '0;
      alu_select <= '0;
      alu_enable <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_select <= grant_id ? req1_op : req0_op;
            alu_in_1   <= grant_id ? req1_a  : req0_a;
            alu_in_2   <= grant_id ? req1_b  : req0_b;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            alu_enable <= 1'b1;
          end
        end
        // Operand registers are left holding their values after the execute cycle
        EXEC: begin
          rsp_result <= alu_bus;
          rsp_carry  <= alu_carry;
          rsp_zero   <= (alu_bus == '0);
          rsp_valid  <= 1'b1;
          alu_enable <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU on the shared bus,
// per-port request queues and an in-order response scoreboard.
module tb_alu_sequencer;

  typedef struct packed {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        carry;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [15:0] alu_in_1, alu_in_2, alu_bus;
  logic [2:0]  alu_select;
  logic        alu_enable, alu_carry;
  logic        rsp_valid, rsp_id, rsp_carry, rsp_zero;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rsp_ready_ctl = 1'b1;
  logic s_ready0, s_ready1, s_en, s_rsp_valid;
  vec_t q0[$];
  vec_t q1[$];
  vec_t sb[$];
  int   acc_id[$];
  int   acc_cyc[$];
  vec_t tbl[12];

  alu_sequencer #(.WIDTH(16), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_select(alu_select),
    .alu_enable(alu_enable), .alu_bus(alu_bus), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd0: alu_ref = {1'b0, a} + {1'b0, b};
      3'd1: alu_ref = {1'b0, a} - {1'b0, b};
      3'd2: alu_ref = {1'b0, a & b};
      3'd3: alu_ref = {1'b0, a | b};
      3'd4: alu_ref = {1'b0, a ^ b};
      3'd5: alu_ref = {1'b0, ~a};
      3'd6: alu_ref = {1'b0, a} + 17'd1;
      default: alu_ref = {1'b0, a} - 17'd1;
    endcase
  endfunction

  // Behavioural ALU: drives garbage when not enabled so a mistimed capture shows up
  logic [16:0] alu_full;
  always_comb begin
    alu_full  = alu_ref(alu_select, alu_in_1, alu_in_2);
    alu_bus   = alu_enable ? alu_full[15:0] : 16'hBEEF;
    alu_carry = alu_enable ? alu_full[16] : 1'b1;
  end

  function automatic vec_t mk(input logic id, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] b);
    logic [16:0] r;
    r = alu_ref(op, a, b);
    mk = '{id, op, a, b, r[15:0], r[16], (r[15:0] == 16'h0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enqueue(input vec_t v);
    if (v.id) q1.push_back(v);
    else q0.push_back(v);
  endtask

  task automatic applyStimulus();
    req0_valid = (q0.size() != 0);
    if (req0_valid) {req0_op, req0_a, req0_b} = {q0[0].op, q0[0].a, q0[0].b};
    else {req0_op, req0_a, req0_b} = 35'($urandom);
    req1_valid = (q1.size() != 0);
    if (req1_valid) {req1_op, req1_a, req1_b} = {q1[0].op, q1[0].a, q1[0].b};
    else {req1_op, req1_a, req1_b} = 35'($urandom);
    rsp_ready = rsp_ready_ctl;
  endtask

  // Samples the handshakes that the coming rising edge will complete
  task automatic checkOutput();
    vec_t e;
    s_ready0    = req0_ready;
    s_ready1    = req1_ready;
    s_en        = alu_enable;
    s_rsp_valid = rsp_valid;
    if (req0_valid && req1_valid) check("ready_onehot", {31'b0, req0_ready & req1_ready}, 0);
    if (req0_valid && req0_ready) begin
      sb.push_back(q0.pop_front());
      acc_id.push_back(0);
      acc_cyc.push_back(cyc);
    end
    if (req1_valid && req1_ready) begin
      sb.push_back(q1.pop_front());
      acc_id.push_back(1);
      acc_cyc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got result %h with nothing outstanding", rsp_result);
      end else begin
        e = sb.pop_front();
        check("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
        check("rsp_result", {16'b0, rsp_result}, {16'b0, e.res});
        check("rsp_carry", {31'b0, rsp_carry}, {31'b0, e.carry});
        check("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < budget) begin
      run_cycle();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0 || sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d ops outstanding after %0d cycles",
               q0.size() + q1.size() + sb.size(), budget);
    end
  endtask

  task automatic wait_rsp_valid(input int budget);
    int n;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!s_rsp_valid && n < budget);
    check("rsp_valid_seen", {31'b0, s_rsp_valid}, 1);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q0.delete(); q1.delete(); sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] snap_res;
    logic        snap_id;

    tbl[0]  = '{1'b1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 3'd2, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd3, 16'h0F0F, 16'h00FF, 16'h0FFF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'd4, 16'h0F0F, 16'h00FF, 16'h0FF0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 3'd5, 16'h0F0F, 16'h00FF, 16'hF0F0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'd6, 16'h0F0F, 16'h00FF, 16'h0F10, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'd7, 16'h0F0F, 16'h00FF, 16'h0F0E, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 3'd7, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 3'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};

    // Reset values, checked while reset is still asserted
    #1 reset = 1'b1;
    #2;
    check("rst_alu_enable", {31'b0, alu_enable}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_id", {31'b0, rsp_id}, 0);
    check("rst_rsp_result", {16'b0, rsp_result}, 0);
    check("rst_rsp_carry", {31'b0, rsp_carry}, 0);
    check("rst_rsp_zero", {31'b0, rsp_zero}, 0);
    check("rst_alu_in_1", {16'b0, alu_in_1}, 0);
    check("rst_alu_in_2", {16'b0, alu_in_2}, 0);
    check("rst_alu_select", {29'b0, alu_select}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single add from port 0: timing of ready, enable and response
    rsp_ready_ctl = 1'b1;
    enqueue('{1'b0, 3'd0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0});
    run_cycle();
    check("t1_ready0", {31'b0, s_ready0}, 1);
    check("t1_en_before", {31'b0, s_en}, 0);
    run_cycle();
    check("t1_en_exec", {31'b0, s_en}, 1);
    check("t1_ready0_exec", {31'b0, s_ready0}, 0);
    check("t1_rsp_valid_exec", {31'b0, s_rsp_valid}, 0);
    check("t1_alu_in_1", {16'b0, alu_in_1}, 32'h5);
    check("t1_alu_in_2", {16'b0, alu_in_2}, 32'h3);
    run_cycle();
    check("t1_en_after", {31'b0, s_en}, 0);
    check("t1_rsp_valid", {31'b0, s_rsp_valid}, 1);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_operand_hold", {16'b0, alu_in_1}, 32'h5);

    // Table of vectors spread over both ports
    for (int i = 0; i < 12; i++) enqueue(tbl[i]);
    drain(100);

    // Continuous requests on both ports after reset: strict alternation from port 0
    sync_reset();
    acc_id.delete();
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      enqueue(mk(1'b0, 3'(i), 16'(16'h1000 + i), 16'h0101));
      enqueue(mk(1'b1, 3'(i + 4), 16'(16'h2000 + i), 16'h0202));
    end
    drain(60);
    check("alt_count", acc_id.size(), 8);
    for (int i = 0; i < acc_id.size(); i++) check("alt_grant", acc_id[i], i % 2);
    for (int i = 1; i < acc_cyc.size(); i++) check("alt_interval", acc_cyc[i] - acc_cyc[i-1], 3);

    // Response backpressure: everything freezes until the consumer is ready
    rsp_ready_ctl = 1'b0;
    enqueue(mk(1'b0, 3'd0, 16'hABCD, 16'h1111));
    enqueue(mk(1'b1, 3'd1, 16'h0100, 16'h0200));
    wait_rsp_valid(10);
    snap_res = rsp_result;
    snap_id  = rsp_id;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("bp_rsp_valid", {31'b0, s_rsp_valid}, 1);
      check("bp_rsp_result", {16'b0, rsp_result}, {16'b0, snap_res});
      check("bp_rsp_id", {31'b0, rsp_id}, {31'b0, snap_id});
      check("bp_ready", {30'b0, s_ready1, s_ready0}, 0);
      check("bp_en", {31'b0, s_en}, 0);
    end
    rsp_ready_ctl = 1'b1;
    run_cycle();
    run_cycle();
    check("bp_resume", {31'b0, s_ready0 | s_ready1}, 1);
    drain(20);

    // Asynchronous reset during the execute cycle
    enqueue(mk(1'b0, 3'd0, 16'h0001, 16'h0001));
    run_cycle();
    check("abort_exec_accept", {31'b0, s_ready0}, 1);
    @(negedge clk);
    applyStimulus();
    #1;
    check("abort_exec_en_pre", {31'b0, alu_enable}, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_exec_en", {31'b0, alu_enable}, 0);
    check("abort_exec_rsp_valid", {31'b0, rsp_valid}, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("abort_no_rsp", {31'b0, s_rsp_valid}, 0);
    end

    // Asynchronous reset while a response is waiting
    rsp_ready_ctl = 1'b0;
    enqueue(mk(1'b1, 3'd4, 16'h5A5A, 16'hFFFF));
    wait_rsp_valid(10);
    #1 reset = 1'b1;
    #1;
    check("abort_resp_rsp_valid", {31'b0, rsp_valid}, 0);
    check("abort_resp_result", {16'b0, rsp_result}, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    rsp_ready_ctl = 1'b1;

    // Normal service after the aborts
    enqueue(mk(1'b1, 3'd1, 16'h0010, 16'h0003));
    enqueue(mk(1'b0, 3'd6, 16'h7FFF, 16'h0000));
    drain(30);
    run_cycle();
    check("final_idle_rsp_valid", {31'b0, s_rsp_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
